// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle LEGv8 controller (master) and its datapath (slave).
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic [10:0]      op;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             reg2loc;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             mem_to_reg;
    logic             reg_write;
    logic             pc_src;
    logic             halted;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg2loc, alu_src_a, alu_src_b,
               alu_op, mem_to_reg, reg_write, pc_src, halted, instret, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg2loc, alu_src_a, alu_src_b,
               alu_op, mem_to_reg, reg_write, pc_src, halted, instret, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory-ready stalls, retired-instruction counting and halt on illegal opcodes.
module multicycle_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRExec  = 4'd6,
        StRWb    = 4'd7,
        StBranch = 4'd8,
        StHalt   = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    logic is_ldur, is_stur, is_cbz, is_rtype;

    assign is_ldur  = (bus.op == 11'b111_1100_0010);
    assign is_stur  = (bus.op == 11'b111_1100_0000);
    assign is_cbz   = (bus.op[10:3] == 8'b1011_0100);
    assign is_rtype = bus.op[10] && (bus.op[7:4] == 4'b0101) && (bus.op[2:0] == 3'b000);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next state and retire
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                if (is_ldur || is_stur) state_d = StMemAdr;
                else if (is_rtype)      state_d = StRExec;
                else if (is_cbz)        state_d = StBranch;
                else                    state_d = ILLEGAL_HALT ? StHalt : StFetch;
            end
            StMemAdr: state_d = is_stur ? StMemWr : StMemRd;
            StMemRd:  if (bus.mem_ready) state_d = StMemWb;
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWr: begin
                if (bus.mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StRExec:  state_d = StRWb;
            StRWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StBranch: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    assign instret_d = instret_q + CNT_W'(retire);

    logic       pc_write, ir_write, iord, mem_read, mem_write, reg2loc, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       mem_to_reg, reg_write, pc_src, halted;

    // Outputs
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg2loc    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                reg2loc   = is_stur || is_cbz;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                reg2loc   = is_stur;
            end
            StMemRd: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                reg2loc   = 1'b1;
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            StRWb:    reg_write = 1'b1;
            StBranch: begin
                reg2loc   = 1'b1;
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = bus.zero;
            end
            StHalt:   halted = 1'b1;
            default:  ;
        endcase
        // Reset suppresses side effects of the state being abandoned this cycle
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            halted    = 1'b0;
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.ir_write   = ir_write;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.reg2loc    = reg2loc;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.pc_src     = pc_src;
    assign bus.halted     = halted;
    assign bus.instret    = instret_q;
    assign bus.state      = state_q;
endmodule
